// File: rtl/controller_pkg.sv
// Shared definitions for the pad command decoder: button bit positions,
// command encodings, direction FSM states and the direction priority resolver.
package controller_pkg;

  localparam int unsigned NUM_BTN   = 11;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_A     = 4;
  localparam int unsigned BTN_B     = 5;
  localparam int unsigned BTN_C     = 6;
  localparam int unsigned BTN_START = 7;
  localparam int unsigned BTN_X     = 8;
  localparam int unsigned BTN_Y     = 9;
  localparam int unsigned BTN_Z     = 10;

  typedef enum logic [2:0] {
    CmdNone     = 3'd0,
    CmdUp       = 3'd1,
    CmdDown     = 3'd2,
    CmdLeft     = 3'd3,
    CmdRight    = 3'd4,
    CmdCleanOn  = 3'd5,
    CmdCleanOff = 3'd6,
    CmdHome     = 3'd7
  } cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StFirst,
    StRepeat
  } dir_state_t;

  // Highest-priority held direction: up > down > left > right.
  // dirs is {right, left, down, up}, i.e. bits [3:0] of the button word.
  function automatic cmd_t resolve_dir(input logic [3:0] dirs);
    if (dirs[BTN_UP]) begin
      return CmdUp;
    end else if (dirs[BTN_DOWN]) begin
      return CmdDown;
    end else if (dirs[BTN_LEFT]) begin
      return CmdLeft;
    end else if (dirs[BTN_RIGHT]) begin
      return CmdRight;
    end
    return CmdNone;
  endfunction

endpackage

// File: rtl/controller_debounce.sv
// Stability filter for the 11-bit pad word: the output only takes a new word
// once the same sample has been seen on STABLE_CYCLES consecutive edges.
module controller_debounce
  import controller_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic               clock_50,
  input  logic               reset_key,
  input  logic [NUM_BTN-1:0] buttons_in,
  output logic [NUM_BTN-1:0] buttons_stable
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

  logic [NUM_BTN-1:0] sample_q;
  logic [NUM_BTN-1:0] stable_q;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               load;

  // Run length of identical samples; restarts at 1 on any change, saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (buttons_in != sample_q) begin
      cnt_d = CntW'(1);
    end else if (cnt_q != CntW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CntW'(1);
    end
    load = (cnt_d == CntW'(STABLE_CYCLES));
  end

  // Sample, run counter and accepted word registers.
  always_ff @(posedge clock_50) begin
    if (reset_key) begin
      sample_q <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sample_q <= buttons_in;
      cnt_q    <= cnt_d;
      if (load) begin
        stable_q <= buttons_in;
      end
    end
  end

  assign buttons_stable = stable_q;

endmodule

// File: rtl/controller_cmd_decoder.sv
// Turns filtered pad presses into single robot commands over a one-deep
// valid/ready slot. Directions emit on press/change and, when the
// CMD_AUTOREPEAT_EN macro is defined, auto-repeat while held.
// Start toggles pause, which mutes direction commands only.
module controller_cmd_decoder
  import controller_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned HOLD_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic               clock_50,
  input  logic               reset_key,
  input  logic [NUM_BTN-1:0] buttons_in,
  output logic               cmd_valid,
  output logic [2:0]         cmd,
  input  logic               cmd_ready,
  output logic               paused,
  output logic [NUM_BTN-1:0] buttons_stable
);

  // Event buttons whose rising edges matter: {start, C, B, A}.
  logic [3:0] evt_now, evt_prev_q, evt_rise;
  logic       paused_q;
  cmd_t       res_dir;

  dir_state_t state_q, state_d;
  cmd_t       dir_q, dir_d;
  logic       dir_emit;
  cmd_t       emit_cmd;

  logic       cmd_valid_q, cmd_valid_d;
  logic [2:0] cmd_q, cmd_d;

  controller_debounce #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debounce (
    .clock_50      (clock_50),
    .reset_key     (reset_key),
    .buttons_in    (buttons_in),
    .buttons_stable(buttons_stable)
  );

  assign evt_now  = {buttons_stable[BTN_START], buttons_stable[BTN_C],
                     buttons_stable[BTN_B], buttons_stable[BTN_A]};
  assign evt_rise = evt_now & ~evt_prev_q;
  assign res_dir  = resolve_dir(buttons_stable[3:0]);

  // Previous event-button levels for 0->1 detection, and the pause toggle.
  always_ff @(posedge clock_50) begin
    if (reset_key) begin
      evt_prev_q <= '0;
      paused_q   <= 1'b0;
    end else begin
      evt_prev_q <= evt_now;
      if (evt_rise[3]) begin
        paused_q <= ~paused_q;
      end
    end
  end

`ifdef CMD_AUTOREPEAT_EN
  localparam int unsigned HoldW = $clog2(HOLD_DELAY + 1);
  localparam int unsigned RepW  = $clog2(REPEAT_PERIOD + 1);

  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RepW-1:0]  rep_cnt_q, rep_cnt_d;

  // Hold and repeat counters; each only runs in its own FSM state.
  always_ff @(posedge clock_50) begin
    if (reset_key) begin
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end
`else
  // Timing parameters have no effect without auto-repeat.
  logic unused_timing;
  assign unused_timing = ^{HOLD_DELAY, REPEAT_PERIOD};
`endif

  // Direction FSM state register.
  always_ff @(posedge clock_50) begin
    if (reset_key) begin
      state_q <= StIdle;
      dir_q   <= CmdNone;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  // Direction FSM next state: follows the resolved direction and flags emits.
  // The FSM keeps tracking while paused; muting happens at emit selection.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    dir_emit = 1'b0;
`ifdef CMD_AUTOREPEAT_EN
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
`endif
    if (res_dir == CmdNone) begin
      state_d = StIdle;
      dir_d   = CmdNone;
`ifdef CMD_AUTOREPEAT_EN
      hold_cnt_d = '0;
      rep_cnt_d  = '0;
`endif
    end else if (state_q == StIdle || res_dir != dir_q) begin
      state_d  = StFirst;
      dir_d    = res_dir;
      dir_emit = 1'b1;
`ifdef CMD_AUTOREPEAT_EN
      hold_cnt_d = '0;
      rep_cnt_d  = '0;
`endif
    end
`ifdef CMD_AUTOREPEAT_EN
    else begin
      case (state_q)
        StFirst: begin
          if (hold_cnt_q + HoldW'(1) == HoldW'(HOLD_DELAY)) begin
            state_d    = StRepeat;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
            dir_emit   = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
        end
        StRepeat: begin
          if (rep_cnt_q + RepW'(1) == RepW'(REPEAT_PERIOD)) begin
            rep_cnt_d = '0;
            dir_emit  = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + RepW'(1);
          end
        end
        default: ;
      endcase
    end
`endif
  end

  // Pick this cycle's emission: an unmuted direction beats A/B/C.
  always_comb begin
    emit_cmd = CmdNone;
    if (dir_emit && !paused_q) begin
      emit_cmd = res_dir;
    end else if (evt_rise[0]) begin
      emit_cmd = CmdCleanOn;
    end else if (evt_rise[1]) begin
      emit_cmd = CmdCleanOff;
    end else if (evt_rise[2]) begin
      emit_cmd = CmdHome;
    end
  end

  // One-deep slot: load when free or being drained, otherwise drop the emit.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;
    if (emit_cmd != CmdNone && (!cmd_valid_q || cmd_ready)) begin
      cmd_valid_d = 1'b1;
      cmd_d       = emit_cmd;
    end else if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
  end

  // Command slot registers.
  always_ff @(posedge clock_50) begin
    if (reset_key) begin
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign paused    = paused_q;

endmodule
